// File: rtl/i2s_in_mux.sv
// Lane buffers plus a packet-granular round-robin merger of 16 I2S lanes into one stream.
// Latency: a word sampled at edge N appears on m_axis at edge N+2 (valid in cycle N+3) when idle.
// Backpressure: m_axis_tready stalls the output register; lane FIFOs absorb it, dropping on full.

// Small synchronous FIFO with a flush input; read data is shown from the head entry.
// Latency: a pushed word is readable the cycle after the push edge.
// Backpressure: a push into a full FIFO is accepted only when a pop happens in the same cycle.
module i2s_in_mux_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         srst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdat,
  output logic [W-1:0] rdat,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO can still take a word when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdat    = mem[rd_ptr];

  // Storage array: written at the tail on every accepted push.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdat;
    end
  end

  // Pointers and occupancy; reset and flush both empty the FIFO.
  always_ff @(posedge clk) begin
    if (!srst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// Top: per-lane FIFOs, IDLE/LOCK arbiter and a single output register.
// Latency: input edge N -> grant edge N+1 -> output load edge N+2.
// Backpressure: pops only when the output register is free or being drained this cycle.
module i2s_in_mux #(
  parameter int CH         = 16,
  parameter int DW         = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             mclki,
  input  logic             srst_n,
  input  logic [CH-1:0]    s_axis_tvalid,
  input  logic [CH*DW-1:0] s_axis_tdata,
  input  logic [CH-1:0]    s_axis_tlast,
  input  logic [CH-1:0]    i_enable,
  input  logic [4*CH-1:0]  i_dst_fpga_index,
  input  logic             i_clear_overflow,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [DW-1:0]    m_axis_tdata,
  output logic             m_axis_tlast,
  output logic [7:0]       m_axis_tuser,
  output logic [CH-1:0]    o_overflow
);

  localparam logic [3:0] LAST_CH = 4'(CH-1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_LOCK = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  grant;
  logic [3:0]  grant_nxt;
  logic [3:0]  grant_inc;
  logic [3:0]  dst;
  logic [3:0]  dst_nxt;
  logic [3:0]  ptr;
  logic [3:0]  ptr_nxt;
  logic        pop_en;
  logic        out_can_load;
  logic        found;
  logic [3:0]  pick;

  logic [CH-1:0] fifo_full;
  logic [CH-1:0] fifo_empty;
  logic [CH-1:0] fifo_push;
  logic [CH-1:0] fifo_pop;
  logic [CH-1:0] fifo_flush;
  logic [CH-1:0] eligible;
  logic [CH-1:0] drop;
  logic [DW:0]   fifo_rdat [CH];
  logic [DW:0]   grant_word;

  // Lane index base+off wrapped modulo CH (off is always below CH).
  function automatic logic [3:0] lane_add(input logic [3:0] base, input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= 32'(CH)) begin
      sum = sum - 32'(CH);
    end
    return 4'(sum);
  endfunction

  // One FIFO per lane holding {tlast, tdata}; a disabled lane is held flushed.
  for (genvar k = 0; k < CH; k++) begin : g_lane
    assign fifo_push[k]  = s_axis_tvalid[k] && i_enable[k];
    assign fifo_flush[k] = !i_enable[k];
    assign fifo_pop[k]   = pop_en && (grant == 4'(k));
    // A word is lost only when the FIFO is full and its head is not leaving this cycle.
    assign drop[k]       = fifo_push[k] && fifo_full[k] && !fifo_pop[k];

    i2s_in_mux_fifo #(
      .W     (DW + 1),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk    (mclki),
      .srst_n (srst_n),
      .flush  (fifo_flush[k]),
      .push   (fifo_push[k]),
      .pop    (fifo_pop[k]),
      .wdat   ({s_axis_tlast[k], s_axis_tdata[k*DW +: DW]}),
      .rdat   (fifo_rdat[k]),
      .full   (fifo_full[k]),
      .empty  (fifo_empty[k])
    );
  end

  assign eligible     = i_enable & ~fifo_empty;
  assign grant_word   = fifo_rdat[grant];
  assign grant_inc    = (grant == LAST_CH) ? 4'd0 : grant + 4'd1;
  assign out_can_load = !m_axis_tvalid || m_axis_tready;

  // Round-robin scan: first eligible lane at or after ptr, wrapping.
  always_comb begin
    logic [3:0] idx;
    found = 1'b0;
    pick  = ptr;
    idx   = ptr;
    for (int i = 0; i < CH; i++) begin
      idx = lane_add(ptr, i);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Arbiter next state: grant in IDLE, stay on one lane in LOCK until tlast or disable.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    dst_nxt   = dst;
    ptr_nxt   = ptr;
    pop_en    = 1'b0;
    case (state)
      S_IDLE: begin
        if (found) begin
          grant_nxt = pick;
          dst_nxt   = i_dst_fpga_index[{pick, 2'b00} +: 4];
          state_nxt = S_LOCK;
        end
      end
      S_LOCK: begin
        if (!i_enable[grant]) begin
          // Lane pulled mid-frame: its FIFO is flushed and the frame ends without tlast.
          state_nxt = S_IDLE;
          ptr_nxt   = grant_inc;
        end else if (!fifo_empty[grant] && out_can_load) begin
          pop_en = 1'b1;
          if (grant_word[DW]) begin
            state_nxt = S_IDLE;
            ptr_nxt   = grant_inc;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Arbiter registers.
  always_ff @(posedge mclki) begin
    if (!srst_n) begin
      state <= S_IDLE;
      grant <= '0;
      dst   <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      dst   <= dst_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Output register: load on pop, hold while stalled, drop valid after a bare handshake.
  always_ff @(posedge mclki) begin
    if (!srst_n) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= '0;
    end else if (pop_en) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= grant_word[DW-1:0];
      m_axis_tlast  <= grant_word[DW];
      m_axis_tuser  <= {dst, grant};
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  // Sticky overflow flags; a drop in the clear cycle keeps its bit set.
  always_ff @(posedge mclki) begin
    if (!srst_n) begin
      o_overflow <= '0;
    end else begin
      o_overflow <= (o_overflow & ~{CH{i_clear_overflow}}) | drop;
    end
  end

endmodule

// File: tb/tb_i2s_in_mux.sv
// Bench for i2s_in_mux: directed steps then randomized rounds checked against a frame-level model.
// Output words are compared in order against a queue filled from round-robin packet rules.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_i2s_in_mux;

  localparam int CH = 16;
  localparam int DW = 32;
  localparam int FD = 8;

  typedef struct packed {
    logic          last;
    logic [7:0]    user;
    logic [DW-1:0] data;
  } ent_t;

  logic             clk = 1'b0;
  logic             srst_n;
  logic [CH-1:0]    s_vld;
  logic [CH*DW-1:0] s_dat;
  logic [CH-1:0]    s_last;
  logic [CH-1:0]    en;
  logic [4*CH-1:0]  dst_bus;
  logic             clr_ovf;
  logic             m_axis_tvalid;
  logic             m_axis_tready;
  logic [DW-1:0]    m_axis_tdata;
  logic             m_axis_tlast;
  logic [7:0]       m_axis_tuser;
  logic [CH-1:0]    o_overflow;

  ent_t       exp_q[$];
  logic [3:0] dst_tab [CH];
  int         checks = 0;
  int         errors = 0;
  int         rdy_pct = 100;

  always #5 clk = ~clk;

  i2s_in_mux #(.CH(CH), .DW(DW), .FIFO_DEPTH(FD)) dut (
    .mclki            (clk),
    .srst_n           (srst_n),
    .s_axis_tvalid    (s_vld),
    .s_axis_tdata     (s_dat),
    .s_axis_tlast     (s_last),
    .i_enable         (en),
    .i_dst_fpga_index (dst_bus),
    .i_clear_overflow (clr_ovf),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tlast     (m_axis_tlast),
    .m_axis_tuser     (m_axis_tuser),
    .o_overflow       (o_overflow)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t mk(input int lane, input logic [DW-1:0] d, input logic l);
    ent_t e;
    e.last = l;
    e.user = {dst_tab[lane], 4'(lane)};
    e.data = d;
    return e;
  endfunction

  task automatic apply_dst();
    for (int k = 0; k < CH; k++) dst_bus[k*4 +: 4] = dst_tab[k];
  endtask

  task automatic clr_in();
    s_vld  = '0;
    s_dat  = '0;
    s_last = '0;
  endtask

  task automatic set_lane(input int k, input logic [DW-1:0] d, input logic l);
    s_vld[k]         = 1'b1;
    s_dat[k*DW +: DW] = d;
    s_last[k]        = l;
  endtask

  // One cycle: pick tready for the coming edge and score any handshake it will complete.
  task automatic tick();
    ent_t e;
    @(negedge clk);
    m_axis_tready = (int'($urandom_range(99)) < rdy_pct);
    if (m_axis_tvalid && m_axis_tready) begin
      chk("out_expected", 64'(exp_q.size() > 0), 64'(1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_word", 64'({m_axis_tlast, m_axis_tuser, m_axis_tdata}), 64'(e));
      end
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int c = 0; c < budget && exp_q.size() != 0; c++) tick();
    chk("drain_empty", 64'(exp_q.size()), 64'(0));
    rdy_pct = 100;
    for (int c = 0; c < 4; c++) tick();
  endtask

  initial begin
    logic [DW-1:0] wd [CH][FD];
    int            len [CH];
    logic [CH-1:0] mask;
    int            ptr_model;
    int            ln;
    int            last_ln;

    srst_n        = 1'b0;
    clr_ovf       = 1'b0;
    en            = '1;
    m_axis_tready = 1'b1;
    clr_in();
    for (int k = 0; k < CH; k++) dst_tab[k] = 4'(15 - k);
    dst_tab[3]  = 4'd5;
    dst_tab[12] = 4'd3;
    apply_dst();

    // Reset state
    tick(); tick(); tick();
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    chk("rst_tdata", 64'(m_axis_tdata), 64'(0));
    chk("rst_tuser", 64'(m_axis_tuser), 64'(0));
    chk("rst_tlast", 64'(m_axis_tlast), 64'(0));
    chk("rst_ovf", 64'(o_overflow), 64'(0));
    srst_n = 1'b1;
    tick();

    // Single frame on lane 3, latency and tuser
    tick(); set_lane(3, 32'hA1, 1'b0);
    exp_q.push_back(mk(3, 32'hA1, 1'b0));
    exp_q.push_back(mk(3, 32'hA2, 1'b1));
    tick(); chk("lat_n", 64'(m_axis_tvalid), 64'(0)); clr_in(); set_lane(3, 32'hA2, 1'b1);
    tick(); chk("lat_n1", 64'(m_axis_tvalid), 64'(0)); clr_in();
    tick();
    chk("sf_w1_vld", 64'(m_axis_tvalid), 64'(1));
    chk("sf_w1_dat", 64'(m_axis_tdata), 64'h0A1);
    chk("sf_w1_user", 64'(m_axis_tuser), 64'h53);
    chk("sf_w1_last", 64'(m_axis_tlast), 64'(0));
    tick();
    chk("sf_w2_dat", 64'(m_axis_tdata), 64'h0A2);
    chk("sf_w2_last", 64'(m_axis_tlast), 64'(1));
    tick();
    chk("sf_end_vld", 64'(m_axis_tvalid), 64'(0));
    wait_drain(50);

    // Round robin from ptr=0, then from ptr=2
    srst_n = 1'b0; tick(); srst_n = 1'b1; tick();
    tick(); set_lane(0, 32'hB0, 1'b1); set_lane(1, 32'hB1, 1'b1); set_lane(15, 32'hBF, 1'b1);
    exp_q.push_back(mk(0, 32'hB0, 1'b1));
    exp_q.push_back(mk(1, 32'hB1, 1'b1));
    exp_q.push_back(mk(15, 32'hBF, 1'b1));
    tick(); clr_in();
    wait_drain(50);
    tick(); set_lane(1, 32'hB11, 1'b1);
    exp_q.push_back(mk(1, 32'hB11, 1'b1));
    tick(); clr_in();
    wait_drain(50);
    tick(); set_lane(0, 32'hC0, 1'b1); set_lane(1, 32'hC1, 1'b1); set_lane(15, 32'hCF, 1'b1);
    exp_q.push_back(mk(15, 32'hCF, 1'b1));
    exp_q.push_back(mk(0, 32'hC0, 1'b1));
    exp_q.push_back(mk(1, 32'hC1, 1'b1));
    tick(); clr_in();
    wait_drain(50);

    // Frame atomicity: lane 2 with a 3-cycle hole, lane 4 waiting
    for (int i = 1; i <= 4; i++) exp_q.push_back(mk(2, 32'(32'h200 + i), 1'(i == 4)));
    exp_q.push_back(mk(4, 32'h400, 1'b1));
    tick(); set_lane(2, 32'h201, 1'b0); set_lane(4, 32'h400, 1'b1);
    tick(); clr_in(); set_lane(2, 32'h202, 1'b0);
    tick(); clr_in();
    tick(); tick();
    tick(); set_lane(2, 32'h203, 1'b0);
    tick(); clr_in(); set_lane(2, 32'h204, 1'b1);
    tick(); clr_in();
    wait_drain(50);

    // Backpressure: 10 stalled cycles with 3 words queued
    rdy_pct = 0;
    for (int i = 1; i <= 3; i++) exp_q.push_back(mk(5, 32'(32'hE0 + i), 1'(i == 3)));
    tick(); set_lane(5, 32'hE1, 1'b0);
    tick(); clr_in(); set_lane(5, 32'hE2, 1'b0);
    tick(); clr_in(); set_lane(5, 32'hE3, 1'b1);
    tick(); clr_in();
    chk("bp_vld", 64'(m_axis_tvalid), 64'(1));
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_stable", 64'({m_axis_tvalid, m_axis_tdata}), 64'({1'b1, 32'hE1}));
    end
    rdy_pct = 100;
    wait_drain(50);

    // Overflow on lane 7 and clear/new-overflow priority
    rdy_pct = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 10) chk("ovf_full_no_drop", 64'(o_overflow), 64'(0));
      clr_in();
      set_lane(7, 32'(32'hF00 + i), 1'(i >= 9));
      if (i <= 9) exp_q.push_back(mk(7, 32'(32'hF00 + i), 1'(i == 9)));
    end
    tick(); chk("ovf_set", 64'(o_overflow), 64'h0080);
    clr_in(); set_lane(7, 32'hF0B, 1'b1); clr_ovf = 1'b1;
    tick(); chk("ovf_clear_vs_new", 64'(o_overflow), 64'h0080);
    clr_in();
    tick(); chk("ovf_cleared", 64'(o_overflow), 64'(0));
    clr_ovf = 1'b0;
    rdy_pct = 100;
    wait_drain(60);

    // Disable lane 9 after its first word; lane 10 served next, stale words flushed
    exp_q.push_back(mk(9, 32'h901, 1'b0));
    exp_q.push_back(mk(10, 32'hA00, 1'b1));
    tick(); set_lane(9, 32'h901, 1'b0); set_lane(10, 32'hA00, 1'b1);
    tick(); clr_in(); set_lane(9, 32'h902, 1'b0);
    tick(); clr_in(); set_lane(9, 32'h903, 1'b1);
    tick(); clr_in(); en[9] = 1'b0;
    tick(); tick();
    en[9] = 1'b1;
    wait_drain(50);
    exp_q.push_back(mk(9, 32'h999, 1'b1));
    tick(); set_lane(9, 32'h999, 1'b1);
    tick(); clr_in();
    wait_drain(50);

    // Reset mid-stream clears every output on the next edge and discards queued data
    rdy_pct = 0;
    tick(); set_lane(12, 32'hC1, 1'b0);
    tick(); clr_in(); set_lane(12, 32'hC2, 1'b1);
    tick(); clr_in();
    tick();
    chk("pre_rst_vld", 64'(m_axis_tvalid), 64'(1));
    chk("pre_rst_user", 64'(m_axis_tuser), 64'h3C);
    srst_n = 1'b0;
    tick();
    chk("mid_rst_outs", 64'({m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata}), 64'(0));
    chk("mid_rst_ovf", 64'(o_overflow), 64'(0));
    exp_q.delete();
    srst_n = 1'b1;
    rdy_pct = 100;
    for (int i = 0; i < 6; i++) tick();

    // Randomized rounds: every selected lane queues one whole frame, drained with random tready
    ptr_model = 0;
    for (int r = 0; r < 25; r++) begin
      for (int k = 0; k < CH; k++) dst_tab[k] = 4'($urandom_range(15));
      apply_dst();
      mask = 16'($urandom_range(65535, 1));
      for (int k = 0; k < CH; k++) begin
        len[k] = int'($urandom_range(FD, 1));
        for (int j = 0; j < FD; j++) wd[k][j] = $urandom;
      end
      last_ln = ptr_model;
      for (int i = 0; i < CH; i++) begin
        ln = (ptr_model + i) % CH;
        if (mask[ln]) begin
          for (int j = 0; j < len[ln]; j++) exp_q.push_back(mk(ln, wd[ln][j], 1'(j == len[ln] - 1)));
          last_ln = ln;
        end
      end
      ptr_model = (last_ln + 1) % CH;
      rdy_pct = 0;
      for (int j = 0; j < FD; j++) begin
        tick();
        clr_in();
        for (int k = 0; k < CH; k++)
          if (mask[k] && j < len[k]) set_lane(k, wd[k][j], 1'(j == len[k] - 1));
      end
      tick(); clr_in();
      rdy_pct = int'($urandom_range(100, 30));
      wait_drain(3000);
      chk("rnd_ovf", 64'(o_overflow), 64'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_in_mux.md
# i2s_in_mux

Per-channel buffer and packet-granular round-robin merger sitting directly downstream of `i2s_in`. It absorbs the 16 independent, non-backpressured 32-bit AXI-stream lanes that `i2s_in` produces, one TDM frame per `tlast`. It serialises them into a single backpressured AXI stream, tagging every word with its source channel and destination FPGA index for the packet builder that follows.

## Interface
- `CH`, 16, number of input lanes (index width fixed at 4 bits)
- `DW`, 32, data width per lane
- `FIFO_DEPTH`, 8, words per lane FIFO (power of two, ≥ 2)

- `mclki` input 1 — clock; the same domain as `i2s_in`
- `srst_n` input 1 — reset, synchronous and active-low
- `s_axis_tvalid` input CH — per-lane word strobe; no tready, so the source never stalls
- `s_axis_tdata` input CH*DW — lane k occupies bits [k*DW +: DW]
- `s_axis_tlast` input CH — last word of a TDM frame
- `i_enable` input CH — lane enable; when low, the lane FIFO is flushed and its input is ignored
- `i_dst_fpga_index` input 4*CH — per-lane destination, sampled when the lane is granted
- `i_clear_overflow` input 1 — clears all `o_overflow` bits
- `m_axis_tvalid` output 1 — output word valid
- `m_axis_tready` input 1 — downstream ready
- `m_axis_tdata` output DW — output word
- `m_axis_tlast` output 1 — copy of the source `tlast`
- `m_axis_tuser` output 8 — {dst_fpga_index[3:0], channel[3:0]}
- `o_overflow` output CH — sticky: set when a word was dropped on a full FIFO

## Operation
- **Lane FIFO**
  - Stores {tlast, tdata}.
  - A write occurs when `s_axis_tvalid[k]` and `i_enable[k]` are both high.
  - If the FIFO is full and not popped that cycle, the word is dropped and `o_overflow[k]` is set.
  - Simultaneous push and pop on a full FIFO is accepted; the count is unchanged.
  - Count width is log2(FIFO_DEPTH)+1.
- **Arbiter FSM**, two states:
  - **IDLE**
    - Scan lanes starting at `ptr` and wrapping modulo CH.
    - Pick the first enabled lane with a non-empty FIFO.
    - Register `grant`, latch `dst = i_dst_fpga_index[grant]`, go to LOCK.
    - If no lane is eligible, stay in IDLE.
  - **LOCK**
    - Pop `grant`'s FIFO when it is non-empty and the output register can load (`!m_axis_tvalid || m_axis_tready`).
    - Popping a word with tlast set → IDLE, and `ptr <= grant+1` (wrapping 15→0).
    - An empty FIFO mid-frame causes a wait in LOCK; no other lane is served.
    - If `i_enable[grant]` drops while in LOCK → flush the FIFO, go to IDLE, `ptr <= grant+1`. The downstream frame is truncated (no tlast is emitted); this is the accepted behaviour.
- **Output register**
  - Loads {tlast, tdata, dst, grant} on a pop.
  - `m_axis_tvalid` is set on load and cleared on a `tready` handshake without a simultaneous load.
  - Data is held stable while `tvalid && !tready`.
- **Overflow flags**: `i_clear_overflow` clears the flags. A new overflow in the same cycle as the clear wins, so that bit stays 1.

## Timing
- **Reset**: all outputs are 0, FIFOs are empty, `ptr` = 0, the FSM is in IDLE. Reset takes effect on the first edge with `srst_n` low and discards in-flight data.
- **Latency** (idle system, `tready` high):
  - Input word sampled at edge N.
  - Grant registered at edge N+1.
  - Output loaded at edge N+2.
  - `m_axis_tvalid` is high in cycle N+3.
- **Throughput**: one word per cycle inside a frame. Between frames there is one idle cycle, spent in IDLE re-arbitrating.
- **Input rate**: `i_enable` and `i_dst_fpga_index` are quasi-static. The aggregate input rate per lane is at most one word per cycle.

## Test plan
- **Single frame**
  - Stimulus: lane 3, enable=1, dst=5, two words 0xA1, 0xA2 (tlast on the second).
  - Required: output 0xA1 with tuser=0x53, then 0xA2 with tlast=1; first word valid 3 cycles after input.
- **Round-robin fairness**
  - Stimulus: lanes 0, 1 and 15 each push one single-word frame in the same cycle.
  - Required: output order 0, 1, 15; a further burst with `ptr`=2 yields order 15, 0, 1.
- **Frame atomicity**
  - Stimulus: lane 2 sends 4 words with a 3-cycle gap after word 2, while lane 4 has data.
  - Required: all 4 lane-2 words are contiguous before any lane-4 word.
- **Backpressure**
  - Stimulus: hold `tready`=0 for 10 cycles with 3 words queued.
  - Required: `m_axis_tdata` is stable throughout; all 3 words are delivered, in order, after release.
- **Overflow**
  - Stimulus: `tready`=0; lane 7 pushes 10 words into FIFO_DEPTH=8.
  - Required: `o_overflow[7]`=1 and the first 8 words are delivered intact.
  - Then pulse `i_clear_overflow` → `o_overflow[7]`=0.
- **Disable and reset mid-frame**
  - Stimulus: drop `i_enable[grant]` after 1 of 3 words.
  - Required: FIFO flushed, next lane served. Asserting `srst_n`=0 mid-stream zeroes all outputs on the next edge.
